// File: rtl/ff_bank_ctrl.sv
// ff_bank_ctrl: sequencer for a WIDTH-bit bank of master-slave JK flip-flops.
// Round-robin arbitrates N_REQ requesters, turns the winner's LOAD/SET/RESET/
// TOGGLE into per-bit j/k, strobes the bank once, waits SETTLE_CYC cycles and
// compares the bank readback against the value predicted at grant time.
//
// Ports:
//   clk, clr        clock; synchronous active-high reset
//   req[N_REQ]      request levels
//   op[2*N_REQ]     per-requester opcode (00 LOAD, 01 SET, 10 RESET, 11 TOGGLE)
//   data[W*N_REQ]   per-requester LOAD value or bit mask
//   q[WIDTH]        bank readback
//   gnt[N_REQ]      one-hot acceptance pulse (IDLE only)
//   j, k[WIDTH]     bank JK inputs
//   ck_en           one-cycle bank clock strobe
//   busy            state != IDLE
//   done, err       completion pulse; readback mismatch qualified by done
//   gnt_id[3]       index of requester being/last served
module ff_bank_ctrl #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [WIDTH*N_REQ-1:0]   data,
  input  logic [WIDTH-1:0]         q,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         j,
  output logic [WIDTH-1:0]         k,
  output logic                     ck_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               gnt_id
);

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, CHECK} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
  } req_t;

  localparam logic [2:0] LAST    = 3'(N_REQ - 1);
  localparam logic [3:0] SET_END = 4'(SETTLE_CYC - 1);

  state_t           state, state_nx;
  logic [2:0]       ptr;
  logic [3:0]       cnt;
  req_t             cur;
  logic [WIDTH-1:0] expq;

  // Round-robin pick: first requester at or after ptr, wrapping at N_REQ.
  logic             hit;
  logic [2:0]       win;
  int               idx;
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = 3'(idx);
      end
    end
  end

  // Winner's operands and the value the bank should read back afterwards.
  logic [1:0]       op_w;
  logic [WIDTH-1:0] data_w, exp_w;
  always_comb begin
    op_w   = op[2*int'(win) +: 2];
    data_w = data[WIDTH*int'(win) +: WIDTH];
    unique case (op_w)
      2'b00:   exp_w = data_w;
      2'b01:   exp_w = q | data_w;
      2'b10:   exp_w = q & ~data_w;
      default: exp_w = q ^ data_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      gnt_id <= '0;
      cur    <= '0;
      expq   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == SETTLE) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && hit) begin
        ptr    <= (win == LAST) ? 3'd0 : win + 3'd1;
        gnt_id <= win;
        cur    <= '{op: op_w, data: data_w};
        expq   <= exp_w;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hit) state_nx = APPLY;
      APPLY:   state_nx = SETTLE;
      SETTLE:  if (cnt == SET_END) state_nx = CHECK;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are gated by clr so an abort is visible immediately and no
  // strobe or done escapes for the aborted operation.
  logic act, drive;
  always_comb begin
    act   = !clr;
    drive = act && (state == APPLY || state == SETTLE);
    gnt   = (act && state == IDLE && hit) ? (N_REQ'(1) << win) : '0;
    ck_en = act && (state == APPLY);
    busy  = act && (state != IDLE);
    done  = act && (state == CHECK);
    err   = done && (q != expq);
  end

  // Per-bit JK encoding; masked-off bits get j=k=0 (hold) except under LOAD,
  // which behaves as a D-type write of every bit.
  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    always_comb begin
      j[b] = 1'b0;
      k[b] = 1'b0;
      if (drive) begin
        unique case (cur.op)
          2'b00:   begin j[b] = cur.data[b];  k[b] = ~cur.data[b]; end
          2'b01:   j[b] = cur.data[b];
          2'b10:   k[b] = cur.data[b];
          default: begin j[b] = cur.data[b];  k[b] = cur.data[b];  end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ff_bank_ctrl.sv
module tb_ff_bank_ctrl;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 0;
  logic           clr;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] data;
  logic [W-1:0]   q, qm;
  logic [N-1:0]   gnt;
  logic [W-1:0]   j, k;
  logic           ck_en, busy, done, err;
  logic [2:0]     gnt_id;
  logic           stuck;

  int checks = 0;
  int errors = 0;

  ff_bank_ctrl #(.N_REQ(N), .WIDTH(W), .SETTLE_CYC(1)) dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .data(data), .q(q),
    .gnt(gnt), .j(j), .k(k), .ck_en(ck_en), .busy(busy), .done(done),
    .err(err), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank, clocked by the strobe; optional q[3] stuck-at-0.
  always @(posedge clk) begin
    if (ck_en)
      for (int b = 0; b < W; b++)
        case ({j[b], k[b]})
          2'b10:   qm[b] <= 1'b1;
          2'b01:   qm[b] <= 1'b0;
          2'b11:   qm[b] <= ~qm[b];
          default: qm[b] <= qm[b];
        endcase
  end
  assign q = stuck ? (qm & 8'hF7) : qm;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1; req = '0; op = '0; data = '0;
    tick(); tick();
    clr = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({gnt, ck_en, done, busy, err, j, k, gnt_id} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: gnt=%b ck_en=%b done=%b busy=%b err=%b j=%h k=%h id=%0d, want all 0",
                 c, gnt, ck_en, done, busy, err, j, k, gnt_id);
      end
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    req = 4'b0001; op[1:0] = 2'b00; data[7:0] = 8'hA5; #1;
    checks++; if (gnt !== 4'b0001 || busy !== 1'b0) begin errors++;
      $display("FAIL load_gnt: gnt=%b busy=%b, want 0001 0", gnt, busy); end
    tick(); req = '0;
    checks++; if (ck_en !== 1'b1 || j !== 8'hA5 || k !== 8'h5A || busy !== 1'b1) begin errors++;
      $display("FAIL load_apply: ck_en=%b j=%h k=%h busy=%b, want 1 a5 5a 1", ck_en, j, k, busy); end
    tick();
    checks++; if (ck_en !== 1'b0 || done !== 1'b0 || j !== 8'hA5) begin errors++;
      $display("FAIL load_settle: ck_en=%b done=%b j=%h, want 0 0 a5", ck_en, done, j); end
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b0 || q !== 8'hA5 || j !== 8'h00 || k !== 8'h00) begin errors++;
      $display("FAIL load_done: done=%b err=%b q=%h j=%h k=%h, want 1 0 a5 00 00", done, err, q, j, k); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL load_idle: busy=%b done=%b, want 0 0", busy, done); end
  endtask

  task automatic test_masked();
    logic [1:0] t_op [3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] t_m  [3] = '{8'h0F, 8'hF0, 8'hFF};
    logic [7:0] t_j  [3] = '{8'h0F, 8'h00, 8'hFF};
    logic [7:0] t_k  [3] = '{8'h00, 8'hF0, 8'hFF};
    logic [7:0] t_q  [3] = '{8'hAF, 8'h0F, 8'hF0};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      req = '0; req[t+1] = 1'b1; op[2*(t+1) +: 2] = t_op[t]; data[8*(t+1) +: 8] = t_m[t];
      tick(); req = '0;
      checks++; if (ck_en !== 1'b1 || j !== t_j[t] || k !== t_k[t] || gnt_id !== 3'(t+1)) begin errors++;
        $display("FAIL masked_apply %0d: ck_en=%b j=%h k=%h id=%0d, want 1 %h %h %0d", t, ck_en, j, k, gnt_id, t_j[t], t_k[t], t+1); end
      tick(); tick();
      checks++; if (done !== 1'b1 || err !== 1'b0 || q !== t_q[t]) begin errors++;
        $display("FAIL masked_done %0d: done=%b err=%b q=%h, want 1 0 %h", t, done, err, q, t_q[t]); end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk); clr = 1; tick(); clr = 0;
    for (int i = 0; i < N; i++) begin op[2*i +: 2] = 2'b00; data[8*i +: 8] = d[i]; end
    req = 4'b1111; #1;
    for (int g = 0; g < 5; g++) begin
      int id;
      id = g % N;
      checks++; if (gnt !== (4'b0001 << id)) begin errors++;
        $display("FAIL rr_gnt %0d: gnt=%b, want %b", g, gnt, 4'b0001 << id); end
      tick();
      checks++; if (gnt_id !== 3'(id) || ck_en !== 1'b1 || gnt !== 4'b0000) begin errors++;
        $display("FAIL rr_apply %0d: id=%0d ck_en=%b gnt=%b, want %0d 1 0000", g, gnt_id, ck_en, gnt, id); end
      tick(); tick();
      checks++; if (done !== 1'b1 || err !== 1'b0 || q !== d[id]) begin errors++;
        $display("FAIL rr_done %0d: done=%b err=%b q=%h, want 1 0 %h", g, done, err, q, d[id]); end
      tick();
    end
    req = '0;
  endtask

  task automatic test_fault();
    stuck = 1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req = 4'b0001; op[1:0] = 2'b00; data[7:0] = (t == 0) ? 8'hFF : 8'h00;
      tick(); req = '0; tick(); tick();
      checks++; if (done !== 1'b1 || err !== (t == 0)) begin errors++;
        $display("FAIL fault_err %0d: done=%b err=%b, want 1 %b", t, done, err, t == 0); end
      tick();
      checks++; if (err !== 1'b0) begin errors++;
        $display("FAIL fault_err_clear %0d: err=%b, want 0", t, err); end
    end
    stuck = 0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    op = '0; data[8*2 +: 8] = 8'h3C; data[8*1 +: 8] = 8'h81;
    req = 4'b0100; #1;
    checks++; if (gnt !== 4'b0100) begin errors++;
      $display("FAIL midop_gnt: gnt=%b, want 0100", gnt); end
    tick(); req = 4'b1010;
    tick(); clr = 1;
    tick(); clr = 0; #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || ck_en !== 1'b0 || j !== 8'h00 || k !== 8'h00 || gnt_id !== 3'd0) begin errors++;
      $display("FAIL midop_abort: done=%b busy=%b ck_en=%b j=%h k=%h id=%0d, want 0 0 0 00 00 0", done, busy, ck_en, j, k, gnt_id); end
    checks++; if (gnt !== 4'b0010) begin errors++;
      $display("FAIL midop_regrant: gnt=%b, want 0010", gnt); end
    tick(); req = '0;
    checks++; if (gnt_id !== 3'd1 || ck_en !== 1'b1 || j !== 8'h81 || k !== 8'h7E) begin errors++;
      $display("FAIL midop_apply: id=%0d ck_en=%b j=%h k=%h, want 1 1 81 7e", gnt_id, ck_en, j, k); end
    tick(); tick();
    checks++; if (done !== 1'b1 || err !== 1'b0 || q !== 8'h81) begin errors++;
      $display("FAIL midop_done: done=%b err=%b q=%h, want 1 0 81", done, err, q); end
  endtask

  initial begin
    qm = '0; stuck = 0;
    test_reset();
    test_load();
    test_masked();
    test_fairness();
    test_fault();
    test_reset_midop();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
